fetch_queue_unit: RTL and testbench

- Parametrised successor to the single-entry instruction fetcher.
- Fetches one instruction per cycle from the icache at the current PC, queries the branch predictor, and pushes {inst, pc, mispredict-pc, predict-taken} into a DEPTH-entry FIFO.
- The decoder drains the FIFO through a valid/ready handshake. Fetch proceeds while decode stalls, until the queue fills.
- ROB rollback flushes the queue and redirects the PC.

---
 rtl/fetch_queue_unit.sv | 117 +++++++++++
 tb/tb_fetch_queue_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Fetch unit with a DEPTH-entry show-ahead instruction queue: one icache fetch per cycle, head visible to decode 1 cycle after push.
// Backpressure: decode stalls via id_ready, fetch halts only when the registered occupancy reaches DEPTH; rdy low freezes everything.
module fetch_queue_unit #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                PC_INC   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic                      if_en,
    input  logic                      if_rb,
    input  logic [ADDR_W-1:0]         rob_rb_pc,
    output logic                      cache_rd_en,
    output logic [ADDR_W-1:0]         cache_rd_addr,
    input  logic                      cache_hit,
    input  logic [INST_W-1:0]         cache_hit_inst,
    output logic [ADDR_W-1:0]         bp_pb_pc,
    output logic [INST_W-1:0]         bp_pb_inst,
    input  logic                      bp_pd_tk,
    input  logic [ADDR_W-1:0]         bp_pd_off,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [INST_W-1:0]         id_inst,
    output logic [ADDR_W-1:0]         id_cur_pc,
    output logic [ADDR_W-1:0]         id_mis_pc,
    output logic                      id_pd_tk,
    output logic [$clog2(DEPTH):0]    q_count
);
    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] INC   = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [ADDR_W-1:0] mis_mem  [DEPTH];
    logic              tk_mem   [DEPTH];

    logic              fetch_en, push, pop;
    logic [ADDR_W-1:0] seq_pc, jmp_pc, mis_pc;

    always_comb begin
        fetch_en = if_en & rdy & ~if_rb & (count_q < FULL);
        push     = fetch_en & cache_hit & (cache_hit_inst != '0);
        pop      = rdy & (count_q != '0) & id_ready & ~if_rb;
        seq_pc   = pc_q + INC;
        jmp_pc   = pc_q + bp_pd_off;
        mis_pc   = bp_pd_tk ? seq_pc : jmp_pc;

        pc_d     = pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (rdy & if_rb) begin
            pc_d    = rob_rb_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
                pc_d   = bp_pd_tk ? jmp_pc : seq_pc;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_q] <= cache_hit_inst;
            pc_mem[tail_q]   <= pc_q;
            mis_mem[tail_q]  <= mis_pc;
            tk_mem[tail_q]   <= bp_pd_tk;
        end
    end

    assign cache_rd_en   = fetch_en;
    assign cache_rd_addr = pc_q;
    assign bp_pb_pc      = pc_q;
    assign bp_pb_inst    = cache_hit_inst;
    assign id_valid      = (count_q != '0);
    assign id_inst       = inst_mem[head_q];
    assign id_cur_pc     = pc_mem[head_q];
    assign id_mis_pc     = mis_mem[head_q];
    assign id_pd_tk      = tk_mem[head_q];
    assign q_count       = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed vector table, queue-full and async-reset sequences, then random traffic against a queue model.
module tb_fetch_queue_unit;
    logic        clk = 1'b0;
    logic        rst_n, rdy, if_en, if_rb;
    logic [31:0] rob_rb_pc;
    logic        cache_rd_en;
    logic [31:0] cache_rd_addr;
    logic        cache_hit;
    logic [31:0] cache_hit_inst;
    logic [31:0] bp_pb_pc, bp_pb_inst;
    logic        bp_pd_tk;
    logic [31:0] bp_pd_off;
    logic        id_valid, id_ready;
    logic [31:0] id_inst, id_cur_pc, id_mis_pc;
    logic        id_pd_tk;
    logic [2:0]  q_count;

    int n_vec = 0;
    int n_err = 0;

    fetch_queue_unit #(.DEPTH(4), .ADDR_W(32), .INST_W(32), .PC_INC(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .if_en(if_en), .if_rb(if_rb), .rob_rb_pc(rob_rb_pc),
        .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr), .cache_hit(cache_hit),
        .cache_hit_inst(cache_hit_inst), .bp_pb_pc(bp_pb_pc), .bp_pb_inst(bp_pb_inst),
        .bp_pd_tk(bp_pd_tk), .bp_pd_off(bp_pd_off), .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_cur_pc(id_cur_pc), .id_mis_pc(id_mis_pc), .id_pd_tk(id_pd_tk),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r, e, b;
        logic [31:0] bpc;
        bit          h;
        logic [31:0] in;
        bit          t;
        logic [31:0] o;
        bit          idr;
        bit          xen;
        logic [31:0] xa;
        bit          xv;
        logic [2:0]  xc;
        logic [31:0] xcur, xmis, xinst;
        bit          xtk;
    } vec_t;

    typedef struct {
        logic [31:0] inst, pc, mis;
        logic        tk;
    } ent_t;

    function automatic vec_t mk(input bit r, e, b, input logic [31:0] bpc, input bit h,
                                input logic [31:0] in, input bit t, input logic [31:0] o, input bit idr,
                                input bit xen, input logic [31:0] xa, input bit xv, input logic [2:0] xc,
                                input logic [31:0] xcur, xmis, xinst, input bit xtk);
        vec_t v;
        v.r = r; v.e = e; v.b = b; v.bpc = bpc; v.h = h; v.in = in; v.t = t; v.o = o; v.idr = idr;
        v.xen = xen; v.xa = xa; v.xv = xv; v.xc = xc; v.xcur = xcur; v.xmis = xmis; v.xinst = xinst; v.xtk = xtk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, e, b, input logic [31:0] bpc, input bit h,
                         input logic [31:0] in, input bit t, input logic [31:0] o, input bit idr);
        rdy = r; if_en = e; if_rb = b; rob_rb_pc = bpc; cache_hit = h;
        cache_hit_inst = in; bp_pd_tk = t; bp_pd_off = o; id_ready = idr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        cyc();
    endtask

    vec_t tv[18];
    ent_t mq[$];
    logic [31:0] mpc;

    initial begin
        // Directed table: each row's expectations reflect all preceding rows.
        tv[0]  = mk(1,0,0,0,     0,0,    0,0,    0, 0,0,     0,0,0,0,0,0);
        tv[1]  = mk(1,1,0,0,     1,'hA0, 0,'h40, 1, 1,0,     0,0,0,0,0,0);
        tv[2]  = mk(1,1,0,0,     1,'hA1, 0,'h40, 1, 1,'h4,   1,1,'h0, 'h40,'hA0,0);
        tv[3]  = mk(1,1,0,0,     1,'hA2, 0,'h40, 1, 1,'h8,   1,1,'h4, 'h44,'hA1,0);
        tv[4]  = mk(1,1,0,0,     1,'hA3, 0,'h40, 1, 1,'hC,   1,1,'h8, 'h48,'hA2,0);
        tv[5]  = mk(1,1,0,0,     1,'hA4, 1,'h20, 1, 1,'h10,  1,1,'hC, 'h4C,'hA3,0);
        tv[6]  = mk(1,1,0,0,     1,'hA5, 0,0,    0, 1,'h30,  1,1,'h10,'h14,'hA4,1);
        tv[7]  = mk(1,1,0,0,     1,'hA6, 0,0,    0, 1,'h34,  1,2,'h10,'h14,'hA4,1);
        tv[8]  = mk(1,1,1,'h100, 1,'hA6, 0,0,    1, 0,'h38,  1,3,'h10,'h14,'hA4,1);
        tv[9]  = mk(1,0,0,0,     0,0,    0,0,    1, 0,'h100, 0,0,0,0,0,0);
        tv[10] = mk(1,1,0,0,     0,'hA9, 0,0,    1, 1,'h100, 0,0,0,0,0,0);
        tv[11] = mk(1,1,0,0,     0,'hAA, 0,0,    1, 1,'h100, 0,0,0,0,0,0);
        tv[12] = mk(1,1,0,0,     0,'hAB, 0,0,    1, 1,'h100, 0,0,0,0,0,0);
        tv[13] = mk(1,1,0,0,     1,0,    0,0,    1, 1,'h100, 0,0,0,0,0,0);
        tv[14] = mk(1,1,0,0,     1,'hA7, 0,'h8,  0, 1,'h100, 0,0,0,0,0,0);
        tv[15] = mk(0,1,0,0,     1,'hA8, 0,0,    1, 0,'h104, 1,1,'h100,'h108,'hA7,0);
        tv[16] = mk(0,1,0,0,     1,'hA8, 0,0,    1, 0,'h104, 1,1,'h100,'h108,'hA7,0);
        tv[17] = mk(1,0,0,0,     0,0,    0,0,    0, 0,'h104, 1,1,'h100,'h108,'hA7,0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tv[i].r, tv[i].e, tv[i].b, tv[i].bpc, tv[i].h, tv[i].in, tv[i].t, tv[i].o, tv[i].idr);
            #1;
            chk($sformatf("tv%0d.rd_en", i), 64'(cache_rd_en), 64'(tv[i].xen));
            chk($sformatf("tv%0d.addr", i),  64'(cache_rd_addr), 64'(tv[i].xa));
            chk($sformatf("tv%0d.valid", i), 64'(id_valid), 64'(tv[i].xv));
            chk($sformatf("tv%0d.count", i), 64'(q_count), 64'(tv[i].xc));
            if (tv[i].xv) begin
                chk($sformatf("tv%0d.cur_pc", i), 64'(id_cur_pc), 64'(tv[i].xcur));
                chk($sformatf("tv%0d.mis_pc", i), 64'(id_mis_pc), 64'(tv[i].xmis));
                chk($sformatf("tv%0d.inst", i),   64'(id_inst), 64'(tv[i].xinst));
                chk($sformatf("tv%0d.pd_tk", i),  64'(id_pd_tk), 64'(tv[i].xtk));
            end
            cyc();
        end

        // Fill to DEPTH with decode stalled, then release one pop.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 1, 32'h1000 + 32'(i), 0, 0, 0);
            cyc();
        end
        #1;
        chk("full.count", 64'(q_count), 64'd4);
        chk("full.rd_en", 64'(cache_rd_en), 64'd0);
        chk("full.addr", 64'(cache_rd_addr), 64'h10);
        drive(1, 1, 0, 0, 1, 32'h2000, 0, 0, 1);
        #1;
        chk("full_pop.rd_en", 64'(cache_rd_en), 64'd0);
        cyc();
        drive(1, 1, 0, 0, 1, 32'h2001, 0, 0, 0);
        #1;
        chk("after_pop.count", 64'(q_count), 64'd3);
        chk("after_pop.rd_en", 64'(cache_rd_en), 64'd1);
        chk("after_pop.cur_pc", 64'(id_cur_pc), 64'h4);
        cyc();
        chk("refill.count", 64'(q_count), 64'd4);
        chk("refill.addr", 64'(cache_rd_addr), 64'h14);

        // Async reset pulse between edges with a full queue.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.count", 64'(q_count), 64'd0);
        chk("arst.valid", 64'(id_valid), 64'd0);
        chk("arst.addr", 64'(cache_rd_addr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 1, 32'h3000, 0, 0, 0);
        #1;
        chk("arst.fetch_en", 64'(cache_rd_en), 64'd1);
        cyc();
        chk("arst.first_pc", 64'(id_cur_pc), 64'h0);
        chk("arst.first_inst", 64'(id_inst), 64'h3000);

        // Random traffic against the queue model.
        do_reset();
        mpc = 32'h0;
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            bit          r, e, b, h, t, idr, exp_en;
            logic [31:0] bpc, in, o;
            ent_t        ne;
            r   = ($urandom_range(0, 9) != 0);
            e   = ($urandom_range(0, 9) != 0);
            b   = ($urandom_range(0, 24) == 0);
            bpc = $urandom & 32'hFFFF_FFFC;
            h   = ($urandom_range(0, 9) < 7);
            in  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            t   = ($urandom_range(0, 9) < 3);
            o   = $urandom_range(0, 255) << 2;
            idr = ($urandom_range(0, 9) < 4);
            drive(r, e, b, bpc, h, in, t, o, idr);
            #1;
            exp_en = e && r && !b && (mq.size() < 4);
            chk("rnd.rd_en", 64'(cache_rd_en), 64'(exp_en));
            chk("rnd.addr", 64'(cache_rd_addr), 64'(mpc));
            chk("rnd.count", 64'(q_count), 64'(mq.size()));
            if (mq.size() != 0) begin
                chk("rnd.cur_pc", 64'(id_cur_pc), 64'(mq[0].pc));
                chk("rnd.mis_pc", 64'(id_mis_pc), 64'(mq[0].mis));
                chk("rnd.inst", 64'(id_inst), 64'(mq[0].inst));
                chk("rnd.pd_tk", 64'(id_pd_tk), 64'(mq[0].tk));
            end else begin
                chk("rnd.valid", 64'(id_valid), 64'd0);
            end
            if (r) begin
                if (b) begin
                    mq.delete();
                    mpc = bpc;
                end else begin
                    bit do_pop, do_push;
                    do_pop  = (mq.size() != 0) && idr;
                    do_push = exp_en && h && (in != 0);
                    ne.inst = in;
                    ne.pc   = mpc;
                    ne.tk   = t;
                    ne.mis  = t ? mpc + 32'd4 : mpc + o;
                    if (do_pop) void'(mq.pop_front());
                    if (do_push) begin
                        mq.push_back(ne);
                        mpc = t ? mpc + o : mpc + 32'd4;
                    end
                end
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
